regfile_mp_scoreboard: RTL

- Parametrised multi-port integer register file for the RV32IM pipeline.
- Provides NRD combinational read ports and NWR write ports. Each read port has a same-cycle write-to-read bypass.
- A per-register pending scoreboard tracks outstanding long-latency writebacks (e.g. MUL/DIV). Decode uses it to stall on RAW hazards.
- Sits between decode (read and issue) and the writeback stages; replaces the single-write 2-read register file.

---
 rtl/regfile_mp_scoreboard.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with a per-register pending scoreboard.
// It has NRD combinational read ports, each with a write-first bypass, and
// NWR write ports, where a higher port index wins on an address conflict.
// The scoreboard tracks registers that are waiting on long-latency
// writebacks, so that decode can stall on RAW hazards.
module regfile_mp_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS),
   parameter int NRD   = 2,
   parameter int NWR   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_pending,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*AW-1:0]    wr_addr,
   input  logic [NWR*XLEN-1:0]  wr_data,
   input  logic [NWR-1:0]       wr_clr,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_addr,
   output logic                 iss_ready,
   input  logic                 flush,
   output logic [AW:0]          pend_cnt
);

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] pend_q;
   logic [NREGS-1:0] pend_d;
   logic [CW-1:0]    pend_cnt_q;
   logic [CW-1:0]    pend_cnt_d;

   logic [NREGS-1:0] clr_vec;
   logic [NREGS-1:0] set_vec;
   logic             set_ok;
   logic [CW-1:0]    dec_cnt;
   logic             inc_bit;

   // One bit per register that a write port is retiring this cycle
   always_comb begin
      clr_vec = '0;
      for (int k = 0; k < NWR; k++) begin
         if (wr_en[k] && wr_clr[k]) begin
            clr_vec[wr_addr[k*AW +: AW]] = 1'b1;
         end
      end
      // x0 is never pending, so a retire aimed at it means nothing
      clr_vec[0] = 1'b0;
   end

   // Issue acceptance: a pending destination stalls unless it retires in the same cycle
   always_comb begin
      iss_ready = !flush && ((iss_addr == '0) || !pend_q[iss_addr] || clr_vec[iss_addr]);
      set_ok    = iss_en && iss_ready && (iss_addr != '0);
      set_vec   = '0;
      if (set_ok) begin
         set_vec[iss_addr] = 1'b1;
      end
   end

   // Read ports: the highest-index matching write is bypassed, otherwise the array is read
   always_comb begin
      rd_data    = '0;
      rd_pending = '0;
      for (int i = 0; i < NRD; i++) begin : rd_port
         logic [AW-1:0]   ra;
         logic [XLEN-1:0] rv;
         ra = rd_addr[i*AW +: AW];
         rv = regs_q[ra];
         for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == ra)) begin
               rv = wr_data[k*XLEN +: XLEN];
            end
         end
         if (ra == '0) begin
            rv = '0;
         end
         rd_data[i*XLEN +: XLEN] = rv;
         // A register retiring this cycle already shows its new value through the bypass
         rd_pending[i] = pend_q[ra] && !clr_vec[ra];
      end
   end

   // Next array contents: apply the writes in ascending port order so the highest index lands last
   always_comb begin
      regs_d = regs_q;
      for (int k = 0; k < NWR; k++) begin
         if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
            regs_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
         end
      end
   end

   // Next scoreboard state and the incrementally maintained pending count
   always_comb begin
      dec_cnt = '0;
      for (int a = 1; a < NREGS; a++) begin
         // A re-set on the same address keeps the bit, so that address does not count down
         if (pend_q[a] && clr_vec[a] && !set_vec[a]) begin
            dec_cnt = dec_cnt + CNT_ONE;
         end
      end
      inc_bit    = set_ok && !pend_q[iss_addr];
      pend_d     = (pend_q & ~clr_vec) | set_vec;
      pend_d[0]  = 1'b0;
      pend_cnt_d = pend_cnt_q + (inc_bit ? CNT_ONE : '0) - dec_cnt;
      if (flush) begin
         pend_d     = '0;
         pend_cnt_d = '0;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < NREGS; a++) begin
            regs_q[a] <= '0;
         end
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign pend_cnt = pend_cnt_q;

endmodule
